// File: rtl/gsensor_spi_master.sv
// rtl/gsensor_spi_master.sv - SPI mode-3 master for accelerometer register reads/writes
module gsensor_spi_master #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [5:0] req_addr,
  input  logic [2:0] req_len,
  input  logic [7:0] req_wdata,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_last,
  output logic       busy,
  output logic       gsensor_sclk,
  output logic       gsensor_cs_,
  output logic       gsensor_mosi,
  input  logic       gsensor_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  // Counter is wide enough for the 2*CLK_DIV inter-frame gap, not just a half-period.
  localparam logic [8:0] HALF_LOAD = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LOAD  = 9'(2 * CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [5:0] bit_q, bit_d;        // rising edges completed in this frame
  logic [5:0] nbits_q, nbits_d;    // total bits in this frame, 16..56
  logic       rw_q, rw_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] wdata_q, wdata_d;
  logic       sclk_q, sclk_d;
  logic       cs_q, cs_d;
  logic       mosi_q, mosi_d;
  logic [7:0] rx_q, rx_d;
  logic       pend_q, pend_d;      // a data byte completed on the last rising edge
  logic       pend_last_q, pend_last_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_last_q, rd_last_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic [2:0] len_eff;
  logic [7:0] cmd_new;
  logic [7:0] tx_byte;
  logic       tx_bit;

  // Clamp the requested length and form the command byte from the live request inputs.
  always_comb begin
    len_eff = req_len;
    if (!req_rw || req_len == 3'd0) begin
      len_eff = 3'd1;
    end else if (req_len == 3'd7) begin
      len_eff = 3'd6;
    end
    cmd_new = {req_rw, (len_eff > 3'd1), req_addr};
  end

  // Byte 0 is the command, byte 1 carries write data, read data bytes send zeros.
  always_comb begin
    tx_byte = 8'h00;
    if (bit_q[5:3] == 3'd0) begin
      tx_byte = cmd_q;
    end else if (bit_q[5:3] == 3'd1 && !rw_q) begin
      tx_byte = wdata_q;
    end
    tx_bit = tx_byte[3'd7 - bit_q[2:0]];
  end

  // Next-state and datapath updates for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    nbits_d     = nbits_q;
    rw_d        = rw_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    rx_d        = rx_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    rd_valid_d  = pend_q;
    rd_last_d   = pend_last_q;
    rd_data_d   = pend_q ? rx_q : rd_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
          mosi_d  = cmd_new[7];
          rw_d    = req_rw;
          cmd_d   = cmd_new;
          wdata_d = req_wdata;
          nbits_d = {3'(len_eff + 3'd1), 3'b000};
          bit_d   = 6'd0;
          cnt_d   = HALF_LOAD;
        end
      end
      SETUP: begin
        if (cnt_q == 9'd0) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          mosi_d  = tx_bit;
          cnt_d   = HALF_LOAD;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != 9'd0) begin
          cnt_d = cnt_q - 9'd1;
        end else begin
          cnt_d = HALF_LOAD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], gsensor_miso};
            bit_d  = bit_q + 6'd1;
            if (rw_q && bit_q[2:0] == 3'd7 && bit_q[5:3] != 3'd0) begin
              pend_d      = 1'b1;
              pend_last_d = ((bit_q + 6'd1) == nbits_q);
            end
          end else if (bit_q == nbits_q) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b0;
            mosi_d = tx_bit;
          end
        end
      end
      HOLD: begin
        if (cnt_q == 9'd0) begin
          state_d = GAP;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      GAP: begin
        if (cnt_q == 9'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any frame and parks the bus idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      bit_q       <= 6'd0;
      nbits_q     <= 6'd0;
      rw_q        <= 1'b0;
      cmd_q       <= 8'h00;
      wdata_q     <= 8'h00;
      sclk_q      <= 1'b1;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      rx_q        <= 8'h00;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      nbits_q     <= nbits_d;
      rw_q        <= rw_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      rx_q        <= rx_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_last      = rd_last_q;
  assign gsensor_sclk = sclk_q;
  assign gsensor_cs_  = cs_q;
  assign gsensor_mosi = mosi_q;

endmodule

// File: tb/tb_gsensor_spi_master.sv
// tb/tb_gsensor_spi_master.sv - self-checking bench for gsensor_spi_master
module tb_gsensor_spi_master;
  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [5:0] req_addr = 6'd0;
  logic [2:0] req_len = 3'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic       gsensor_sclk;
  logic       gsensor_cs_;
  logic       gsensor_mosi;
  logic       gsensor_miso = 1'b0;

  always #5 clk = ~clk;

  gsensor_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .req_wdata    (req_wdata),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .busy         (busy),
    .gsensor_sclk (gsensor_sclk),
    .gsensor_cs_  (gsensor_cs_),
    .gsensor_mosi (gsensor_mosi),
    .gsensor_miso (gsensor_miso)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rw;
    logic [5:0]  addr;
    logic [2:0]  len;
    logic [7:0]  wdata;
    logic [7:0]  exp_cmd;
    int          exp_n;
    logic [47:0] sens;
  } vec_t;

  // Sensor model, bus monitor and read-data scoreboard.
  logic [47:0] sens = '0;
  logic [63:0] mosi_sr = '0;
  logic [8:0]  exp_q[$];
  logic [8:0]  e;
  int fall_cnt = 0, rise_cnt = 0, cs_low_cyc = 0, cs_high_run = 0, last_gap = 0;
  int rd_cnt = 0, since_rise = 100, cyc = 0, stray_sclk = 0;
  logic sclk_prev = 1'b1, cs_prev = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cs_prev && !gsensor_cs_) begin
      fall_cnt = 0; rise_cnt = 0; mosi_sr = '0; cs_low_cyc = 0; last_gap = cs_high_run;
    end
    if (gsensor_cs_ === 1'b1) begin
      cs_high_run++;
      if (gsensor_sclk !== 1'b1 && !rst) stray_sclk++;
    end else begin
      cs_high_run = 0;
      cs_low_cyc++;
    end
    since_rise++;
    if (!gsensor_cs_ && sclk_prev && !gsensor_sclk) begin
      if (fall_cnt >= 8 && fall_cnt < 56) gsensor_miso = sens[47 - (fall_cnt - 8)];
      else gsensor_miso = 1'b0;
      fall_cnt++;
    end
    if (!gsensor_cs_ && !sclk_prev && gsensor_sclk) begin
      rise_cnt++;
      mosi_sr = {mosi_sr[62:0], gsensor_mosi};
      since_rise = 0;
    end
    if (rd_valid === 1'b1) begin
      rd_cnt++;
      check("rd_valid one cycle after rise", since_rise, 1);
      if (exp_q.size() == 0) begin
        check("rd_valid with empty scoreboard", rd_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e[7:0]);
        check("rd_last", rd_last, e[8]);
      end
    end
    sclk_prev = gsensor_sclk;
    cs_prev   = gsensor_cs_;
  end

  int acc_cnt = 0, acc_cyc_last = 0, acc_cyc_prev = 0;
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      acc_cnt++;
      acc_cyc_prev = acc_cyc_last;
      acc_cyc_last = cyc;
    end
  end

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 5000) begin @(negedge clk); guard++; end
    check({tag, " returns idle"}, busy, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, nb, n_before, guard;
    string tag;
    tag = $sformatf("vec%0d", idx);
    n  = v.exp_n;
    nb = 8 * (1 + n);
    sens = v.sens;
    if (v.rw) for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), v.sens[47 - 8 * i -: 8]});
    n_before = rd_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_rw = v.rw; req_addr = v.addr; req_len = v.len; req_wdata = v.wdata;
    guard = 0;
    while (!req_ready && guard < 1000) begin @(negedge clk); guard++; end
    check({tag, " ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0; req_rw = ~v.rw; req_addr = ~v.addr; req_len = 3'd3; req_wdata = ~v.wdata;
    check({tag, " busy after accept"}, busy, 1);
    wait_idle(tag);
    check({tag, " command byte"}, (mosi_sr >> (nb - 8)) & 64'hff, v.exp_cmd);
    check({tag, " rising edges"}, rise_cnt, nb);
    check({tag, " cs low cycles"}, cs_low_cyc, CLK_DIV * (2 + 2 * nb));
    check({tag, " rd_valid count"}, rd_cnt - n_before, v.rw ? n : 0);
    if (v.rw) check({tag, " mosi zero in data"}, mosi_sr & ((64'd1 << (nb - 8)) - 64'd1), 0);
    else      check({tag, " write data byte"}, (mosi_sr >> (nb - 16)) & 64'hff, v.wdata);
    check({tag, " scoreboard drained"}, exp_q.size(), 0);
  endtask

  vec_t vecs[6];

  initial begin
    int guard, base, rd0, edges;
    logic sp;
    //           rw    addr   len   wdata  cmd    n  sensor bytes
    vecs[0] = '{1'b0, 6'h2D, 3'd1, 8'h08, 8'h2D, 1, 48'h0};
    vecs[1] = '{1'b1, 6'h00, 3'd1, 8'h00, 8'h80, 1, 48'hE5_0000000000};
    vecs[2] = '{1'b1, 6'h32, 3'd6, 8'h00, 8'hF2, 6, 48'h11_22_33_44_55_66};
    vecs[3] = '{1'b1, 6'h0F, 3'd0, 8'h00, 8'h8F, 1, 48'h5A_0000000000};
    vecs[4] = '{1'b1, 6'h05, 3'd7, 8'h00, 8'hC5, 6, 48'hA1_B2_C3_D4_E5_F6};
    vecs[5] = '{1'b0, 6'h31, 3'd5, 8'hA5, 8'h31, 1, 48'h0};

    repeat (3) @(posedge clk);
    #1;
    check("reset cs_", gsensor_cs_, 1);
    check("reset sclk", gsensor_sclk, 1);
    check("reset mosi", gsensor_mosi, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_last", rd_last, 0);
    check("reset rd_data", rd_data, 0);
    check("reset busy", busy, 0);
    check("reset req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Back-to-back: req_valid held high, second accept only after the gap.
    base = acc_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 6'h20; req_len = 3'd1; req_wdata = 8'h47;
    guard = 0;
    while (acc_cnt < base + 2 && guard < 1000) begin @(negedge clk); guard++; end
    req_valid = 1'b0;
    check("b2b accepts", acc_cnt - base, 2);
    check("b2b accept spacing", acc_cyc_last - acc_cyc_prev, CLK_DIV * (2 + 2 * 16) + 2 * CLK_DIV + 1);
    check("b2b cs high gap >= 2*CLK_DIV", (last_gap >= 2 * CLK_DIV), 1);
    wait_idle("b2b");

    // Reset in the middle of the third data byte of a 6-byte read.
    sens = 48'h11_22_33_44_55_66;
    for (int i = 0; i < 6; i++) exp_q.push_back({(i == 5), sens[47 - 8 * i -: 8]});
    rd0 = rd_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 6'h32; req_len = 3'd6;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (fall_cnt < 28 && guard < 2000) begin @(negedge clk); guard++; end
    check("abort reached byte 3", (fall_cnt >= 28), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort cs_", gsensor_cs_, 1);
    check("abort sclk", gsensor_sclk, 1);
    check("abort busy", busy, 0);
    check("abort rd_valid", rd_valid, 0);
    check("abort bytes before reset", rd_cnt - rd0, 2);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rd0 = rd_cnt;
    edges = 0;
    sp = gsensor_sclk;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gsensor_sclk !== sp) edges++;
      sp = gsensor_sclk;
    end
    check("abort no sclk edges", edges, 0);
    check("abort no rd_valid", rd_cnt - rd0, 0);
    check("abort stays idle", busy, 0);
    check("sclk high while cs_ high", stray_sclk, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
